// File: rtl/cnt_pkg.sv
// Shared definitions for the cnt_timer_sched slice: FSM encoding, slice width
// and the round-robin one-hot pick used by the arbiter.
package cnt_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // One-hot winner among the first n bits of req, searching from last+1 with wrap.
  function automatic logic [7:0] rr_pick(input logic [7:0] req,
                                         input logic [2:0] last,
                                         input int unsigned n);
    logic [7:0]  g;
    int unsigned j;
    g = '0;
    for (int unsigned i = 1; i <= n; i++) begin
      j = (32'(last) + i) % n;
      if (g == '0 && req[j[2:0]]) g[j[2:0]] = 1'b1;
    end
    return g;
  endfunction

endpackage

// File: rtl/cnt_slice.sv
// 4-bit synchronous-load up-counter slice with CET/CEP enables and
// combinational terminal count for ripple cascading.
module cnt_slice
  import cnt_pkg::*;
(
  input  logic               CP,
  input  logic               MR,
  input  logic               CET,
  input  logic               CEP,
  input  logic               PE,
  input  logic [SLICE_W-1:0] P,
  output logic [SLICE_W-1:0] Q,
  output logic               TC
);

  always_ff @(posedge CP or posedge MR) begin
    if (MR)              Q <= '0;
    else if (PE)         Q <= P;
    else if (CET && CEP) Q <= Q + 1'b1;
  end

  assign TC = CET & (Q == '1);

endmodule

// File: rtl/cnt_timer_sched.sv
// One-shot timer shared among NREQ requesters over a cascaded-slice counter.
// CNT_FIXED_PRIO_EN selects fixed-priority arbitration instead of round-robin.
module cnt_timer_sched
  import cnt_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 8
) (
  input  logic              CP,
  input  logic              MR,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] preset,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [W-1:0]      cur_q
);

  localparam int unsigned NS = W / SLICE_W;
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   win_idx;
  logic [NREQ-1:0] win_oh;
  logic [W-1:0]    load_val;
  logic            tc_top;
  logic            abort;

`ifndef CNT_FIXED_PRIO_EN
  logic [IW-1:0] last;
  logic [7:0]    req8;
  logic [7:0]    pick8;

  always_comb begin
    req8    = 8'(req);
    pick8   = rr_pick(req8, 3'(last), NREQ);
    win_idx = '0;
    for (int unsigned k = 0; k < 8; k++)
      if (pick8[k]) win_idx = IW'(k);
  end

  always_ff @(posedge CP or posedge MR) begin
    if (MR)                         last <= IW'(NREQ - 1);
    else if (state == DONE || abort) last <= idx;
  end
`else
  always_comb begin
    logic found;
    found   = 1'b0;
    win_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (req[k] && !found) begin
        win_idx = IW'(k);
        found   = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    win_oh          = '0;
    win_oh[win_idx] = 1'b1;
    load_val        = '0;
    for (int unsigned i = 0; i < NREQ; i++)
      if (IW'(i) == idx) load_val = preset[i*W +: W];
  end

  // Each slice's CET is the previous slice's TC; the top TC (all-ones while
  // in RUN) drops CEP everywhere so the counter never wraps.
  for (genvar s = 0; s < NS; s++) begin : g_slice
    logic cet;
    logic tc;
    if (s == 0) begin : g_first
      assign cet = (state == RUN);
    end else begin : g_next
      assign cet = g_slice[s-1].tc;
    end
    cnt_slice u_slice (
      .CP  (CP),
      .MR  (MR),
      .CET (cet),
      .CEP (~tc_top),
      .PE  (state == LOAD),
      .P   (load_val[s*SLICE_W +: SLICE_W]),
      .Q   (cur_q[s*SLICE_W +: SLICE_W]),
      .TC  (tc)
    );
  end

  assign tc_top = g_slice[NS-1].tc;
  assign abort  = (state == LOAD || state == RUN) && !req[idx];

  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      state <= IDLE;
      idx   <= '0;
      gnt   <= '0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          idx   <= win_idx;
          gnt   <= win_oh;
          state <= LOAD;
        end
        LOAD: begin
          if (abort) begin
            gnt   <= '0;
            state <= IDLE;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            gnt   <= '0;
            state <= IDLE;
          end else if (tc_top) begin
            state <= DONE;
          end
        end
        DONE: begin
          gnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign done = (state == DONE) ? gnt : '0;
  assign busy = (state != IDLE);

endmodule

// File: doc/cnt_timer_sched.md
Name: cnt_timer_sched

Overview:
- Shares one W-bit up-counter among NREQ requesters as a one-shot timer.
- The counter is built from cascaded 4-bit slices with load, enable and terminal-count.
- A round-robin arbiter grants one requester, loads its preset, counts to all-ones, then pulses that requester's done.
- Sits between timeout-hungry control blocks and the counter datapath; sequences PE/CET/CEP for the slices.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 8, counter width in bits; multiple of 4 (W/4 slices)

Ports:
CP  input  1  clock, rising edge
MR  input  1  reset, asynchronous, active-high
req  input  NREQ  per-requester timer request; level, held until done
preset  input  NREQ*W  per-requester start value; slice i = bits [i*W +: W]
gnt  output  NREQ  one-hot grant; high LOAD through DONE
done  output  NREQ  one-cycle pulse to granted requester at terminal count
busy  output  1  state != IDLE
cur_q  output  W  live counter value

Behaviour:
- Reset (MR=1, any time, including mid-count): state IDLE; gnt=0, done=0, busy=0; cur_q=0; RR pointer last=NREQ-1, so req[0] wins first.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - If |req, pick the winner by RR, searching from last+1 upward with wrap.
  - Latch idx, set gnt[idx], go LOAD.
  - Else stay; counter holds.
- LOAD:
  - Slices PE active; at the edge Q <= preset[idx]. The preset is sampled only on this edge.
  - Go RUN.
- RUN:
  - CET/CEP=1 to the lowest slice; each upper slice enabled by the AND of all lower TCs (ripple carry).
  - If Q == all-ones at the edge: no increment, go DONE. Else Q <= Q+1.
  - RUN lasts (2^W-1-preset)+1 cycles; preset = all-ones gives 1 RUN cycle.
- DONE:
  - done[idx]=1 for exactly this cycle; gnt[idx] stays high; Q holds.
  - Next edge: last <= idx, gnt=0, go IDLE.
- Latency: req seen at edge e0 → gnt after e0 → done high in the cycle after edge e(k+2), where k = 2^W-1-preset.
- Abort: if req[idx] drops in LOAD or RUN, the next edge goes to IDLE with gnt=0 and no done. last is still updated to idx for fairness. A drop during DONE still delivers done.
- A new grant is never issued in the DONE cycle, so there is at least one IDLE cycle between grants.
- Requests from non-granted requesters are ignored until IDLE.
- Counter wrap never occurs; the increment is suppressed at all-ones.
- preset changes outside the LOAD edge have no effect.

Optional Feature:
CNT_FIXED_PRIO_EN
- Defined: the arbiter is fixed-priority (lowest asserted index wins); the last pointer is unused.
- Undefined (default): round-robin as described above.

Decomposition:
- Shared package cnt_pkg:
  - FSM state enum: IDLE=2'd0, LOAD=2'd1, RUN=2'd2, DONE=2'd3.
  - Slice width constant SLICE_W=4.
  - Function for RR one-hot pick.
- Sub-module cnt_slice:
  - 4-bit counter with inputs CP, MR, CET, CEP, PE (active-high load), P[3:0]; outputs Q[3:0], TC.
  - TC = CET & (Q==4'hF), combinational.
  - Synchronous load; asynchronous active-high reset to 0.
- cnt_timer_sched instantiates W/4 slices via generate, plus the FSM and arbiter.

Test Plan:
- Reset mid-RUN (W=8, preset=8'h10, assert MR at Q=8'h20) → gnt=0, busy=0, cur_q=0 immediately; req[0] then wins first.
- Single req[2], preset=8'hFD, asserted before e0 → gnt=4'b0100 after e0; cur_q FD/FE/FF after e1/e2/e3; done=4'b0100 only in the cycle after e4; IDLE after e5.
- req=4'b1111 held, all presets 8'hFF → grants in order 0,1,2,3,0; each done a single pulse; at least one IDLE cycle between gnts.
- Cascade carry: preset=8'h0E → cur_q goes 0E→0F→10; upper slice increments only when lower TC=1; done after 242 RUN cycles.
- Abort: req[1] dropped at cur_q=8'hF0 → no done, next IDLE; req[3] pending is granted next.
- With CNT_FIXED_PRIO_EN, req=4'b1010 held → req[1] granted every round; req[3] is never granted while req[1] stays high.
